vga_sync_monitor: RTL and testbench

//  Receive-side checker for the 1280x1024@60 VGA timing (108 MHz pixel clk).

---
 rtl/vga_sync_monitor.sv | 198 +++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame timing from hsync/vsync,
// declares lock after consecutive good frames and recovers visible x/y.
//
// state   | meaning
// SEARCH  | timing unknown, checks ignored, waiting for a vsync fall
// ACQUIRE | counting consecutive frames in which every check passed
// LOCKED  | timing verified; any failed check drops back to SEARCH
module vga_sync_monitor #(
    parameter int H_TOTAL     = 1688,
    parameter int H_SYNC      = 112,
    parameter int V_TOTAL     = 1066,
    parameter int V_SYNC      = 3,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12,
    parameter int H_VIS       = 1280,
    parameter int V_VIS       = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          blank_n,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          pix_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic          locked,
    output logic          timing_err,
    output logic [CW-1:0] meas_h_total,
    output logic [CW-1:0] meas_v_total
);

    localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_WD_C    = CW'(2 * H_TOTAL);
    localparam logic [CW-1:0] H_WD_M1_C = CW'(2 * H_TOTAL - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [10:0]   X_MAX     = 11'(H_VIS - 1);
    localparam logic [10:0]   Y_MAX     = 11'(V_VIS - 1);
    localparam logic [3:0]    LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t        state;
    logic [3:0]    good;
    logic          frame_bad;

    logic          hs_r, vs_r, bl_r, hs_p, vs_p;
    logic          hs_fall, hs_rise, vs_fall, vs_rise;
    logic [CW-1:0] hcnt, hwcnt, lcnt, vscnt;
    logic [CW-1:0] h_period, v_frame;
    logic          seen_hf, seen_vf;
    logic [10:0]   xc, yc, x_base, y_base;
    logic          line_vis;
    logic          h_bad, hw_bad, v_bad, vw_bad, timeout, viol;

    assign hs_fall  = hs_p & ~hs_r;
    assign hs_rise  = ~hs_p & hs_r;
    assign vs_fall  = vs_p & ~vs_r;
    assign vs_rise  = ~vs_p & vs_r;

    // An hsync fall coincident with the vsync fall belongs to the ending frame
    assign h_period = hcnt + 1'b1;
    assign v_frame  = lcnt + CW'(hs_fall);

    // Width checks only trust counts whose starting edge was actually seen
    assign h_bad    = hs_fall & seen_hf & (h_period != H_TOTAL_C);
    assign hw_bad   = hs_rise & seen_hf & (hwcnt != H_SYNC_C);
    assign vw_bad   = vs_rise & seen_vf & (vscnt != V_SYNC_C);
    assign v_bad    = vs_fall & (v_frame != V_TOTAL_C);
    assign timeout  = ~hs_fall & (hcnt == H_WD_M1_C);
    assign viol     = h_bad | hw_bad | v_bad | vw_bad | timeout;

    always_comb begin
        x_base = hs_fall ? 11'd0 : xc;
        y_base = yc;
        if (vs_fall)
            y_base = 11'd0;
        else if (hs_fall && line_vis)
            y_base = (yc == Y_MAX) ? Y_MAX : yc + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            bl_r         <= 1'b0;
            hs_p         <= 1'b1;
            vs_p         <= 1'b1;
            hcnt         <= '0;
            hwcnt        <= '0;
            lcnt         <= '0;
            vscnt        <= '0;
            seen_hf      <= 1'b0;
            seen_vf      <= 1'b0;
            meas_h_total <= '0;
            meas_v_total <= '0;
            xc           <= '0;
            yc           <= '0;
            line_vis     <= 1'b0;
            x            <= '0;
            y            <= '0;
            pix_valid    <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            hs_r        <= hsync;
            vs_r        <= vsync;
            bl_r        <= blank_n;
            hs_p        <= hs_r;
            vs_p        <= vs_r;
            line_start  <= hs_fall;
            frame_start <= vs_fall;
            pix_valid   <= bl_r;

            if (hs_fall) begin
                hcnt         <= '0;
                meas_h_total <= h_period;
                seen_hf      <= 1'b1;
            end else if (hcnt != H_WD_C) begin
                hcnt <= hcnt + 1'b1;
            end

            if (hs_fall)
                hwcnt <= CW'(1);
            else if (!hs_r && hwcnt != CNT_MAX)
                hwcnt <= hwcnt + 1'b1;

            if (vs_fall) begin
                meas_v_total <= v_frame;
                lcnt         <= '0;
                vscnt        <= CW'(hs_fall);
                seen_vf      <= 1'b1;
            end else if (hs_fall) begin
                if (lcnt != CNT_MAX)
                    lcnt <= lcnt + 1'b1;
                if (!vs_r && vscnt != CNT_MAX)
                    vscnt <= vscnt + 1'b1;
            end

            x        <= x_base;
            y        <= y_base;
            yc       <= y_base;
            xc       <= bl_r ? ((x_base == X_MAX) ? X_MAX : x_base + 11'd1) : x_base;
            line_vis <= (hs_fall | vs_fall) ? bl_r : (line_vis | bl_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEARCH;
            good       <= '0;
            frame_bad  <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state     <= ACQUIRE;
                        good      <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_fall) begin
                        frame_bad <= 1'b0;
                        if (frame_bad || viol) begin
                            timing_err <= 1'b1;
                            good       <= '0;
                        end else if (good == LOCK_C - 4'd1) begin
                            good   <= LOCK_C;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good <= good + 4'd1;
                        end
                    end else if (viol) begin
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (viol) begin
                        timing_err <= 1'b1;
                        locked     <= 1'b0;
                        state      <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Randomized bench for vga_sync_monitor on a scaled-down timing, compared every
// cycle against an event/timestamp reference model of the sync rules.
module tb_vga_sync_monitor;

    localparam int H_TOTAL     = 48;
    localparam int H_SYNC      = 6;
    localparam int V_TOTAL     = 20;
    localparam int V_SYNC      = 3;
    localparam int LOCK_FRAMES = 2;
    localparam int CW          = 8;
    localparam int H_VIS       = 24;
    localparam int V_VIS       = 10;
    localparam int H_VIS0      = 14;
    localparam int V_VIS0      = 6;

    logic          clk = 1'b0;
    logic          rst_n, hsync, vsync, blank_n;
    logic [10:0]   x, y;
    logic          pix_valid, line_start, frame_start, locked, timing_err;
    logic [CW-1:0] meas_h_total, meas_v_total;

    vga_sync_monitor #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
        .LOCK_FRAMES(LOCK_FRAMES), .CW(CW), .H_VIS(H_VIS), .V_VIS(V_VIS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .x(x), .y(y), .pix_valid(pix_valid), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int pv; int ls; int fs; int lk; int te; int mh; int mv;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_iter   = 0;
    exp_t exp_a, exp_b;

    // reference model state: timestamps of events rather than running counters
    int t = 0, t_hf = 0, lines = 0, vlow = 0, xc = 0, yc = 0;
    int mode = 0, good = 0, mh = 0, mv = 0;
    bit m_hs_p = 1, m_vs_p = 1, armed_h = 0, armed_v = 0, line_vis = 0, fbad = 0, lk = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t exp_zero();
        exp_t e;
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        return e;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit h, input bit v, input bit b);
        bit   hf, hr, vf, vr, viol, err;
        int   per, nl;
        exp_t e;
        e = exp_zero();
        if (!r) begin
            m_hs_p = 1; m_vs_p = 1; t_hf = t - 1; armed_h = 0; armed_v = 0;
            lines = 0; vlow = 0; xc = 0; yc = 0; line_vis = 0;
            mode = 0; good = 0; fbad = 0; lk = 0; mh = 0; mv = 0;
            exp_a = exp_zero();
        end else begin
            hf = m_hs_p && !h; hr = !m_hs_p && h;
            vf = m_vs_p && !v; vr = !m_vs_p && v;
            viol = 0; err = 0;
            if (hf) begin
                per = imin(t - t_hf, 2 * H_TOTAL + 1);
                if (armed_h && per != H_TOTAL) viol = 1;
                mh = per;
            end else if (t - t_hf == 2 * H_TOTAL) begin
                viol = 1;
            end
            if (hr && armed_h && (t - t_hf) != H_SYNC) viol = 1;
            if (hf) begin t_hf = t; armed_h = 1; end

            if (vf) begin
                nl = lines + int'(hf);
                if (nl != V_TOTAL) viol = 1;
                mv = nl; lines = 0; vlow = int'(hf); armed_v = 1;
            end else if (hf) begin
                lines++;
                if (!v) vlow++;
            end
            if (vr && armed_v && vlow != V_SYNC) viol = 1;

            if (vf) begin yc = 0; line_vis = 0; end
            else if (hf) begin if (line_vis) yc++; line_vis = 0; end
            if (hf) xc = 0;
            e.x = imin(xc, H_VIS - 1);
            e.y = imin(yc, V_VIS - 1);
            if (b) begin xc++; line_vis = 1; end

            case (mode)
                0: if (vf) begin mode = 1; good = 0; fbad = 0; end
                1: if (vf) begin
                       if (fbad || viol) begin err = 1; good = 0; end
                       else begin good++; if (good == LOCK_FRAMES) begin mode = 2; lk = 1; end end
                       fbad = 0;
                   end else if (viol) fbad = 1;
                default: if (viol) begin err = 1; lk = 0; mode = 0; end
            endcase

            e.pv = int'(b); e.ls = int'(hf); e.fs = int'(vf);
            e.lk = int'(lk); e.te = int'(err); e.mh = mh; e.mv = mv;
            m_hs_p = h; m_vs_p = v;
        end
        t++;
        exp_b = e;
    endtask

    task automatic step(input bit r, input bit h, input bit v, input bit b);
        @(negedge clk);
        if (n_iter >= 2) begin
            check_eq("x", 32'(x), exp_a.x);
            check_eq("y", 32'(y), exp_a.y);
            check_eq("pix_valid", 32'(pix_valid), exp_a.pv);
            check_eq("line_start", 32'(line_start), exp_a.ls);
            check_eq("frame_start", 32'(frame_start), exp_a.fs);
            check_eq("locked", 32'(locked), exp_a.lk);
            check_eq("timing_err", 32'(timing_err), exp_a.te);
            check_eq("meas_h", 32'(meas_h_total), exp_a.mh);
            check_eq("meas_v", 32'(meas_v_total), exp_a.mv);
        end
        exp_a   = exp_b;
        rst_n   = r;
        hsync   = h;
        vsync   = v;
        blank_n = b;
        model_step(r, h, v, b);
        n_iter++;
    endtask

    task automatic send_line(input int period, input int hsw, input bit v,
                             input int vis_len, input int rst_at);
        for (int c = 0; c < period; c++)
            step(c != rst_at, c >= hsw, v, (c >= H_VIS0) && (c < H_VIS0 + vis_len));
    endtask

    // kind: 0 none, 1 line +/-1, 2 hsync width +/-1, 3 watchdog, 4 reset, 5 vsync width
    task automatic send_frame(input int kind, input int fline, input bit wide_y);
        int per, hsw, vl, ra, vs_lines;
        bit vis;
        vs_lines = (kind == 5) ? V_SYNC + 1 : V_SYNC;
        for (int l = 0; l < V_TOTAL; l++) begin
            per = H_TOTAL; hsw = H_SYNC; vl = H_VIS; ra = -1;
            vis = wide_y ? (l >= 3 && l < V_TOTAL - 1) : (l >= V_VIS0 && l < V_VIS0 + V_VIS);
            if (l == fline) begin
                case (kind)
                    1: per = ($urandom_range(0, 1) != 0) ? H_TOTAL + 1 : H_TOTAL - 1;
                    2: hsw = ($urandom_range(0, 1) != 0) ? H_SYNC + 1 : H_SYNC - 1;
                    3: per = 2 * H_TOTAL + 4;
                    4: ra  = int'($urandom_range(1, H_TOTAL - 1));
                    default: ;
                endcase
            end
            if ($urandom_range(0, 15) == 0) vl = H_VIS + 3;
            send_line(per, hsw, l >= vs_lines, vis ? vl : 0, ra);
        end
    endtask

    initial begin
        int kind;
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
        exp_a = exp_zero();
        exp_b = exp_zero();
        repeat (4) step(0, 1, 1, 0);
        check_eq("rst_x", 32'(x), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_meas_h", 32'(meas_h_total), 0);
        check_eq("rst_pix_valid", 32'(pix_valid), 0);

        repeat (4) send_frame(0, -1, 1'b0);
        check_eq("lock_nominal", 32'(locked), 1);
        check_eq("meas_h_nominal", 32'(meas_h_total), H_TOTAL);
        check_eq("meas_v_nominal", 32'(meas_v_total), V_TOTAL);

        for (int r = 0; r < 7; r++) begin
            kind = (r < 6) ? r : int'($urandom_range(1, 5));
            send_frame(kind, int'($urandom_range(0, V_TOTAL - 1)), $urandom_range(0, 1) != 0);
            repeat (5) send_frame(0, -1, $urandom_range(0, 1) != 0);
            check_eq("relock", 32'(locked), 1);
        end

        repeat (3) step(1, 1, 1, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
